// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
// Purpose: arbiter state encoding and byte width used by uart_tx_arbiter.
// Ports: none (package).
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin selector
// Purpose: picks the first asserted request at or after ptr, wrapping mod N.
// Ports:
//   req    [N-1:0]  request vector
//   ptr    [IW-1:0] index searched first
//   onehot [N-1:0]  one-hot winner (0 when none)
//   idx    [IW-1:0] winner index (0 when none)
//   any             at least one request asserted
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk offsets from farthest to nearest so the nearest hit is the last
  // assignment and therefore wins.
  always_comb begin
    int k;
    k      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) begin
        onehot    = '0;
        onehot[k] = 1'b1;
        idx       = IW'(k);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, frame-locked arbiter in front of one UART_TX
// Purpose: shares a single UART_TX between NUM_REQ byte streams, one byte at a
//   time, keeping the transmitter with one requester until it sends a last byte.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid_i  [NUM_REQ]      per-requester byte valid
//   req_data_i   [NUM_REQ*8]    per-requester byte, requester k at [8k+7:8k]
//   req_last_i   [NUM_REQ]      byte ends the frame (releases the lock)
//   req_ready_o  [NUM_REQ]      one-hot accept strobe, byte taken on this edge
//   uart_tx_en_o                one-cycle transmit pulse
//   uart_tx_data_o [8]          latched byte for UART_TX
//   uart_tx_busy_i              UART_TX busy
//   grant_o      [NUM_REQ]      one-hot current owner, 0 when idle
//   timeout_o                   one-cycle pulse when busy never rose
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*BYTE_W-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]          req_last_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic                        uart_tx_en_o,
  output logic [BYTE_W-1:0]           uart_tx_data_o,
  input  logic                        uart_tx_busy_i,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic                        timeout_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT);

  arb_state_t         state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      owner;
  logic               lock;
  logic [CW-1:0]      cnt;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [IW-1:0]      sel_idx;
  logic [IW-1:0]      next_ptr;
  logic               done_now;
  logic [BYTE_W-1:0]  req_byte [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_byte[g] = req_data_i[g*BYTE_W +: BYTE_W];
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req    (req_valid_i),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Ready is gated by rst_n so it drops the instant reset asserts, even while
  // requesters still hold valid.
  always_comb begin
    req_ready_o = '0;
    if (rst_n) begin
      if (state == IDLE && pick_any && !uart_tx_busy_i) begin
        req_ready_o = pick_onehot;
      end else if (state == HOLD && req_valid_i[owner]) begin
        req_ready_o[owner] = 1'b1;
      end
    end
  end

  assign sel_idx  = (state == HOLD) ? owner : pick_idx;
  assign next_ptr = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

  // The timeout fires on the edge where the count steps to BUSY_TIMEOUT-1, so
  // timeout_o is high exactly BUSY_TIMEOUT cycles after the enable pulse.
  assign done_now = !uart_tx_busy_i &&
                    ((state == WAIT_DONE) ||
                     (state == WAIT_BUSY && cnt == CW'(BUSY_TIMEOUT - 2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      owner          <= '0;
      lock           <= 1'b0;
      cnt            <= '0;
      uart_tx_en_o   <= 1'b0;
      uart_tx_data_o <= '0;
      grant_o        <= '0;
      timeout_o      <= 1'b0;
    end else begin
      uart_tx_en_o <= 1'b0;
      timeout_o    <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          // In HOLD the ready vector is already the owner's one-hot.
          if (|req_ready_o) begin
            uart_tx_data_o <= req_byte[sel_idx];
            lock           <= ~req_last_i[sel_idx];
            owner          <= sel_idx;
            grant_o        <= req_ready_o;
            uart_tx_en_o   <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (uart_tx_busy_i) begin
            state <= WAIT_DONE;
          end else begin
            cnt <= cnt + CW'(1);
            if (done_now) timeout_o <= 1'b1;
          end
        end
        WAIT_DONE: begin
        end
        default: state <= IDLE;
      endcase

      if (done_now) begin
        if (lock) begin
          state <= HOLD;
        end else begin
          state   <= IDLE;
          grant_o <= '0;
          ptr     <= next_ptr;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0]   req_last = '1;
  logic [N-1:0]   req_ready;
  logic           en;
  logic [7:0]     tx_data;
  logic           busy = 1'b0;
  logic [N-1:0]   grant;
  logic           timeout;

  int total = 0;
  int bad = 0;
  int busy_mode = 0;
  int rem = 0;
  int cyc = 0;
  int multi = 0;
  int acc_q[$];
  logic [7:0] en_q[$];

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(T)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_last_i     (req_last),
    .req_ready_o    (req_ready),
    .uart_tx_en_o   (en),
    .uart_tx_data_o (tx_data),
    .uart_tx_busy_i (busy),
    .grant_o        (grant),
    .timeout_o      (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ($countones(req_ready) > 1) multi <= multi + 1;
    for (int k = 0; k < N; k++) if (req_ready[k]) acc_q.push_back(k);
    if (en) en_q.push_back(tx_data);
  end

  // UART_TX stand-in: mode 0 answers each enable with 3 busy cycles,
  // mode 1 keeps busy low, mode 2 keeps busy high.
  always @(negedge clk) begin
    if (busy_mode == 0) begin
      if (en) rem = 3;
      else if (rem > 0) rem = rem - 1;
      busy = (rem > 0);
    end else begin
      rem  = 0;
      busy = (busy_mode == 2);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_last = '1;
    req_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (grant == '0 && !busy && !en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_one(input int k);
    @(negedge clk);
    req_valid = '0;
    req_valid[k] = 1'b1;
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (en !== 1'b0) begin bad++; $display("FAIL reset_en got=%0b exp=0", en); end
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", tx_data); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010;
    req_data[15:8] = 8'h41;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    total++; if (en !== 1'b1) begin bad++; $display("FAIL single_en got=%0b exp=1", en); end
    total++; if (tx_data !== 8'h41) begin bad++; $display("FAIL single_data got=%h exp=41", tx_data); end
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL single_grant got=%b exp=0010", grant); end
    @(negedge clk);
    total++; if (en !== 1'b0) begin bad++; $display("FAIL single_en_width got=%0b exp=0", en); end
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL single_idle got=busy exp=idle"); end
    // ptr must now be 2: with everyone valid, requester 2 is offered first.
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ptr got=%b exp=0100", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_contention();
    bit ok;
    int exp_q[5] = '{0, 1, 2, 3, 0};
    do_reset();
    acc_q.delete();
    en_q.delete();
    multi = 0;
    req_data = 32'hA3A2A1A0;
    req_valid = 4'b1111;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (en_q.size() >= 5) break;
    end
    req_valid = '0;
    wait_idle(ok);
    total++; if (acc_q.size() != 5 || en_q.size() != 5) begin bad++; $display("FAIL cont_count got=%0d/%0d exp=5/5", acc_q.size(), en_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < acc_q.size() && i < en_q.size()) begin
        total++; if (acc_q[i] != exp_q[i]) begin bad++; $display("FAIL cont_grant[%0d] got=%0d exp=%0d", i, acc_q[i], exp_q[i]); end
        total++; if (en_q[i] !== 8'hA0 + 8'(exp_q[i])) begin bad++; $display("FAIL cont_data[%0d] got=%h exp=%h", i, en_q[i], 8'hA0 + 8'(exp_q[i])); end
      end
    end
    total++; if (multi != 0) begin bad++; $display("FAIL cont_onehot got=%0d exp=0", multi); end
  endtask

  task automatic test_frame_lock();
    bit ok;
    int i;
    int exp_a[4] = '{2, 2, 2, 0};
    logic [7:0] exp_d[4] = '{8'h10, 8'h11, 8'h12, 8'h55};
    do_reset();
    send_one(1);
    wait_idle(ok);
    acc_q.delete();
    en_q.delete();
    i = 0;
    req_data[7:0] = 8'h55;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (acc_q.size() >= 4) break;
      req_valid = 4'b0001;
      if (i < 3) begin
        req_valid[2] = 1'b1;
        req_data[23:16] = 8'h10 + 8'(i);
        req_last[2] = (i == 2);
      end
      #1;
      if (req_ready[2]) i++;
    end
    req_valid = '0;
    req_last = '1;
    wait_idle(ok);
    total++; if (acc_q.size() != 4 || en_q.size() != 4) begin bad++; $display("FAIL lock_count got=%0d/%0d exp=4/4", acc_q.size(), en_q.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < acc_q.size() && k < en_q.size()) begin
        total++; if (acc_q[k] != exp_a[k]) begin bad++; $display("FAIL lock_grant[%0d] got=%0d exp=%0d", k, acc_q[k], exp_a[k]); end
        total++; if (en_q[k] !== exp_d[k]) begin bad++; $display("FAIL lock_data[%0d] got=%h exp=%h", k, en_q[k], exp_d[k]); end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int t_en, t_to, to_cnt;
    logic [N-1:0] pending;
    acc_q.delete();
    en_q.delete();
    busy_mode = 1;
    t_en = -1;
    t_to = -1;
    to_cnt = 0;
    pending = 4'b1010;
    req_data[15:8] = 8'h61;
    req_data[31:24] = 8'h63;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      req_valid = pending;
      if (en && t_en < 0) t_en = cyc;
      if (timeout) begin
        to_cnt++;
        if (t_to < 0) t_to = cyc;
      end
      if (to_cnt == 2) break;
      #1;
      pending = pending & ~req_ready;
    end
    req_valid = '0;
    busy_mode = 0;
    wait_idle(ok);
    total++; if (t_to - t_en != T) begin bad++; $display("FAIL to_delay got=%0d exp=%0d", t_to - t_en, T); end
    total++; if (to_cnt != 2) begin bad++; $display("FAIL to_pulses got=%0d exp=2", to_cnt); end
    total++; if (acc_q.size() != 2) begin bad++; $display("FAIL to_count got=%0d exp=2", acc_q.size()); end
    else begin
      total++; if (acc_q[0] != 1 || acc_q[1] != 3) begin bad++; $display("FAIL to_order got=%0d,%0d exp=1,3", acc_q[0], acc_q[1]); end
    end
  endtask

  task automatic test_busy_start();
    bit ok;
    busy_mode = 2;
    @(negedge clk);
    req_valid = 4'b0001;
    req_data[7:0] = 8'h77;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL busy_hold[%0d] got=%b exp=0000", c, req_ready); end
    end
    @(negedge clk);
    #1;
    busy_mode = 0;
    busy = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL busy_release got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    total++; if (en !== 1'b1 || tx_data !== 8'h77) begin bad++; $display("FAIL busy_issue got=%0b/%h exp=1/77", en, tx_data); end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    send_one(0);
    wait_idle(ok);
    @(negedge clk);
    req_valid = 4'b0010;
    req_data[15:8] = 8'h88;
    req_last = 4'b1101;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_ready got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL mid_grant got=%b exp=0010", grant); end
    req_valid = 4'b0101;
    rst_n = 1'b0;
    #1;
    total++; if (en !== 1'b0 || grant !== 4'b0 || req_ready !== 4'b0) begin bad++; $display("FAIL mid_reset got=%0b/%b/%b exp=0/0000/0000", en, grant, req_ready); end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_restart got=%b exp=0001", req_ready); end
    req_valid = '0;
    req_last = '1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_frame_lock();
    test_timeout();
    test_busy_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
